// File: rtl/ysyx_clint_arb_pkg.sv
// Shared types for the CLINT read arbiter.
// The optional response timeout is enabled with YSYX_CLINT_ARB_TIMEOUT_EN.
package ysyx_clint_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ysyx_rr_arb2.sv
// Two-way round-robin picker: on contention the requester
// that was not granted last time wins.
module ysyx_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = 1'b0;
        unique case (1'b1)
            (req == 2'b11): gnt_id = ~last;
            (req == 2'b10): gnt_id = 1'b1;
            default:        gnt_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/ysyx_clint_arbiter.sv
// Two-requester read arbiter in front of the CLINT MMIO read port.
// Define YSYX_CLINT_ARB_TIMEOUT_EN to add the s_rvalid timeout.
module ysyx_clint_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clock,
    input  logic            reset,

    input  logic [XLEN-1:0] m0_araddr,
    input  logic            m0_arvalid,
    output logic            m0_arready,
    output logic [XLEN-1:0] m0_rdata,
    output logic [1:0]      m0_rresp,
    output logic            m0_rvalid,
    input  logic            m0_rready,

    input  logic [XLEN-1:0] m1_araddr,
    input  logic            m1_arvalid,
    output logic            m1_arready,
    output logic [XLEN-1:0] m1_rdata,
    output logic [1:0]      m1_rresp,
    output logic            m1_rvalid,
    input  logic            m1_rready,

    output logic [XLEN-1:0] s_araddr,
    output logic            s_arvalid,
    input  logic [XLEN-1:0] s_rdata,
    input  logic [1:0]      s_rresp,
    input  logic            s_rvalid
);

    import ysyx_clint_arb_pkg::*;

    arb_state_e      state_q, state_d;
    logic            last_q, last_d;
    logic            gnt_q, gnt_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [1:0]      rresp_q, rresp_d;

`ifdef YSYX_CLINT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic pick_valid;
    logic pick_id;
    logic in_idle;
    logic in_busy;
    logic in_resp;
    logic gnt_rready;

    ysyx_rr_arb2 u_rr (
        .req       ({m1_arvalid, m0_arvalid}),
        .last      (last_q),
        .gnt_valid (pick_valid),
        .gnt_id    (pick_id)
    );

    assign in_idle    = (state_q == IDLE);
    assign in_busy    = (state_q == BUSY);
    assign in_resp    = (state_q == RESP);
    assign gnt_rready = gnt_q ? m1_rready : m0_rready;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
`ifdef YSYX_CLINT_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BUSY;
                    gnt_d   = pick_id;
                    last_d  = pick_id;
                    addr_d  = pick_id ? m1_araddr : m0_araddr;
`ifdef YSYX_CLINT_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                if (s_rvalid) begin
                    state_d = RESP;
                    rdata_d = s_rdata;
                    rresp_d = s_rresp;
                end
`ifdef YSYX_CLINT_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            // Any s_rvalid seen here is the trailing pulse of the
            // request we already completed, so it is dropped.
            RESP: begin
                if (gnt_rready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            addr_q  <= '0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
`ifdef YSYX_CLINT_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
`ifdef YSYX_CLINT_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign m0_arready = in_idle && pick_valid && !pick_id;
    assign m1_arready = in_idle && pick_valid && pick_id;

    assign s_arvalid = in_busy;
    assign s_araddr  = in_busy ? addr_q : '0;

    assign m0_rvalid = in_resp && !gnt_q;
    assign m1_rvalid = in_resp && gnt_q;

    assign m0_rdata  = m0_rvalid ? rdata_q : '0;
    assign m1_rdata  = m1_rvalid ? rdata_q : '0;
    assign m0_rresp  = m0_rvalid ? rresp_q : RESP_OKAY;
    assign m1_rresp  = m1_rvalid ? rresp_q : RESP_OKAY;

endmodule

// File: tb/tb_ysyx_clint_arbiter.sv
// Directed bench for ysyx_clint_arbiter with a registered CLINT model.
// Timeout steps run when YSYX_CLINT_ARB_TIMEOUT_EN is defined.
module tb_ysyx_clint_arbiter;

    localparam logic [31:0] RTC_ADDR    = 32'h0200_bff8;
    localparam logic [31:0] RTC_ADDR_UP = 32'h0200_bffc;
    localparam logic [31:0] BAD_ADDR    = 32'h0000_1000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] m0_araddr = '0;
    logic        m0_arvalid = 1'b0;
    logic        m0_arready;
    logic [31:0] m0_rdata;
    logic [1:0]  m0_rresp;
    logic        m0_rvalid;
    logic        m0_rready = 1'b1;
    logic [31:0] m1_araddr = '0;
    logic        m1_arvalid = 1'b0;
    logic        m1_arready;
    logic [31:0] m1_rdata;
    logic [1:0]  m1_rresp;
    logic        m1_rvalid;
    logic        m1_rready = 1'b1;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid = 1'b0;

    logic [31:0] mtime_lo = 32'h0000_1234;
    logic [31:0] mtime_hi = 32'h0000_0000;
    logic        stuck = 1'b0;

    int checks = 0;
    int errors = 0;

    ysyx_clint_arbiter #(.XLEN(32), .TIMEOUT(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .m0_araddr  (m0_araddr),
        .m0_arvalid (m0_arvalid),
        .m0_arready (m0_arready),
        .m0_rdata   (m0_rdata),
        .m0_rresp   (m0_rresp),
        .m0_rvalid  (m0_rvalid),
        .m0_rready  (m0_rready),
        .m1_araddr  (m1_araddr),
        .m1_arvalid (m1_arvalid),
        .m1_arready (m1_arready),
        .m1_rdata   (m1_rdata),
        .m1_rresp   (m1_rresp),
        .m1_rvalid  (m1_rvalid),
        .m1_rready  (m1_rready),
        .s_araddr   (s_araddr),
        .s_arvalid  (s_arvalid),
        .s_rdata    (s_rdata),
        .s_rresp    (s_rresp),
        .s_rvalid   (s_rvalid)
    );

    always #5 clock = ~clock;

    // CLINT model: data combinational on address, rvalid one cycle late.
    always @(posedge clock) s_rvalid <= s_arvalid && !stuck;

    always_comb begin
        s_rdata = 32'hbad0_bad0;
        s_rresp = 2'b10;
        if (s_araddr == RTC_ADDR) begin
            s_rdata = mtime_lo;
            s_rresp = 2'b00;
        end else if (s_araddr == RTC_ADDR_UP) begin
            s_rdata = mtime_hi;
            s_rresp = 2'b00;
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Waits for a grant, then follows it to the response beat.
    task automatic txn(input string tag, input int exp_id,
                       input logic [31:0] exp_addr,
                       input logic [31:0] exp_data,
                       input logic [1:0] exp_resp,
                       input int exp_wait, input int lat,
                       input bit keep);
        int n;
        n = 0;
        #1;
        while (!(m0_arready || m1_arready) && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_wait"}, n, exp_wait);
        chk({tag, "_ar0"}, {31'd0, m0_arready}, {31'd0, exp_id == 0});
        chk({tag, "_ar1"}, {31'd0, m1_arready}, {31'd0, exp_id == 1});
        tick();
        if (!keep) begin
            if (exp_id == 0) m0_arvalid = 1'b0;
            else m1_arvalid = 1'b0;
        end
        #1;
        chk({tag, "_sarv"}, {31'd0, s_arvalid}, 32'd1);
        chk({tag, "_saddr"}, s_araddr, exp_addr);
        chk({tag, "_noar"}, {30'd0, m1_arready, m0_arready}, 32'd0);
        for (int i = 2; i < lat; i++) begin
            tick();
            chk({tag, "_early"}, {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        end
        tick();
        if (exp_id == 0) begin
            chk({tag, "_rv"}, {30'd0, m1_rvalid, m0_rvalid}, 32'd1);
            chk({tag, "_rdata"}, m0_rdata, exp_data);
            chk({tag, "_rresp"}, {30'd0, m0_rresp}, {30'd0, exp_resp});
            chk({tag, "_odata"}, m1_rdata, 32'd0);
        end else begin
            chk({tag, "_rv"}, {30'd0, m1_rvalid, m0_rvalid}, 32'd2);
            chk({tag, "_rdata"}, m1_rdata, exp_data);
            chk({tag, "_rresp"}, {30'd0, m1_rresp}, {30'd0, exp_resp});
            chk({tag, "_odata"}, m0_rdata, 32'd0);
        end
        chk({tag, "_sdrop"}, {31'd0, s_arvalid}, 32'd0);
    endtask

    initial begin
        // Reset state
        do_reset();
        #1;
        chk("rst_ar", {30'd0, m1_arready, m0_arready}, 32'd0);
        chk("rst_rv", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        chk("rst_sarv", {31'd0, s_arvalid}, 32'd0);
        chk("rst_saddr", s_araddr, 32'd0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);

        // Single request from m0
        tick();
        m0_araddr = RTC_ADDR;
        m0_arvalid = 1'b1;
        txn("single", 0, RTC_ADDR, 32'h0000_1234, 2'b00, 0, 3, 1'b0);

        // Trailing s_rvalid must not produce a second response
        tick();
        chk("stale_rv", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        chk("stale_sarv", {31'd0, s_arvalid}, 32'd0);
        mtime_lo = 32'h5555_5555;
        m0_araddr = RTC_ADDR_UP;
        m0_arvalid = 1'b1;
        txn("fresh", 0, RTC_ADDR_UP, 32'h0000_0000, 2'b00, 0, 3, 1'b0);
        tick();
        chk("fresh_rv", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);

        // Slave error code passes through
        m1_araddr = BAD_ADDR;
        m1_arvalid = 1'b1;
        txn("slverr", 1, BAD_ADDR, 32'hbad0_bad0, 2'b10, 0, 3, 1'b0);

        // Contention from reset alternates 0,1,0,1 back to back
        do_reset();
        mtime_lo = 32'h0000_1234;
        mtime_hi = 32'h0000_0042;
        m0_araddr = RTC_ADDR;
        m1_araddr = RTC_ADDR_UP;
        m0_arvalid = 1'b1;
        m1_arvalid = 1'b1;
        txn("rr0", 0, RTC_ADDR, 32'h0000_1234, 2'b00, 0, 3, 1'b1);
        txn("rr1", 1, RTC_ADDR_UP, 32'h0000_0042, 2'b00, 1, 3, 1'b1);
        txn("rr2", 0, RTC_ADDR, 32'h0000_1234, 2'b00, 1, 3, 1'b1);
        txn("rr3", 1, RTC_ADDR_UP, 32'h0000_0042, 2'b00, 1, 3, 1'b1);
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
        tick();
        chk("rr_idle", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);

        // m1 response backpressure holds data and blocks m0
        do_reset();
        mtime_hi = 32'h0000_00a5;
        m1_rready = 1'b0;
        m1_araddr = RTC_ADDR_UP;
        m1_arvalid = 1'b1;
        txn("bp1", 1, RTC_ADDR_UP, 32'h0000_00a5, 2'b00, 0, 3, 1'b0);
        m0_araddr = RTC_ADDR;
        m0_arvalid = 1'b1;
        mtime_hi = 32'hffff_ffff;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_rv", {30'd0, m1_rvalid, m0_rvalid}, 32'd2);
            chk("bp_data", m1_rdata, 32'h0000_00a5);
            chk("bp_noar", {30'd0, m1_arready, m0_arready}, 32'd0);
        end
        m1_rready = 1'b1;
        txn("bp0", 0, RTC_ADDR, 32'h0000_1234, 2'b00, 1, 3, 1'b0);

        // Reset while BUSY drops the in-flight read
        do_reset();
        m0_araddr = RTC_ADDR;
        m0_arvalid = 1'b1;
        #1;
        chk("rb_ar0", {31'd0, m0_arready}, 32'd1);
        tick();
        m0_arvalid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rb_busy", {31'd0, s_arvalid}, 32'd1);
        tick();
        reset = 1'b0;
        #1;
        chk("rb_sarv", {31'd0, s_arvalid}, 32'd0);
        chk("rb_saddr", s_araddr, 32'd0);
        chk("rb_ar", {30'd0, m1_arready, m0_arready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rb_norv", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        end
        mtime_hi = 32'h0000_0007;
        m1_araddr = RTC_ADDR_UP;
        m1_arvalid = 1'b1;
        txn("rb_m1", 1, RTC_ADDR_UP, 32'h0000_0007, 2'b00, 0, 3, 1'b0);

`ifdef YSYX_CLINT_ARB_TIMEOUT_EN
        // Stuck slave completes with SLVERR after the timeout
        tick();
        stuck = 1'b1;
        m0_araddr = RTC_ADDR;
        m0_arvalid = 1'b1;
        txn("tmo", 0, RTC_ADDR, 32'h0000_0000, 2'b10, 0, 17, 1'b0);
        stuck = 1'b0;
        tick();
        chk("tmo_idle", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
